fht_input_loader: RTL

- Upstream neighbour of fht_control. Accepts one frame of N = 2^N_BIT time-domain samples over a valid/ready stream.
- Writes each sample into the four FHT data banks (bank set A) in bit-reversed order.
- When the frame is complete, it pulses iSTART of fht_control, then blocks new input until that transform finishes (oRDY high again).

---
 rtl/fht_input_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fht_input_loader.sv
`default_nettype none
// ============================================================================
// Module   : fht_input_loader
// Brief    : Streams one frame of samples into the four FHT banks in
//            bit-reversed order, then kicks fht_control and waits for it.
// Revision : 1.0
// ============================================================================
module fht_input_loader #(
    parameter int D_BIT = 16,
    parameter int A_BIT = 8,
    parameter int N_BIT = 10
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    input  logic             iSOF,
    output logic             oREADY,
    input  logic             iFHT_RDY,
    output logic [A_BIT-1:0] oADDR,
    output logic [D_BIT-1:0] oDATA,
    output logic             oWE_0,
    output logic             oWE_1,
    output logic             oWE_2,
    output logic             oWE_3,
    output logic             oSTART,
    output logic             oBUSY,
    output logic             oSOF_ERR,
    output logic [7:0]       oFRAME_CNT
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_KICK      = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    localparam logic [N_BIT:0] c_LAST = {1'b0, {N_BIT{1'b1}}};
    localparam logic [N_BIT:0] c_ONE  = {{N_BIT{1'b0}}, 1'b1};

    state_t           state_q;
    logic [N_BIT:0]   cnt_q;
    logic [3:0]       we_q;
    logic [A_BIT-1:0] addr_q;
    logic [D_BIT-1:0] data_q;
    logic             start_q;
    logic             sof_err_q;
    logic [7:0]       frame_cnt_q;

    logic             w_accept;
    logic             w_write;
    logic [N_BIT-1:0] w_index;
    logic [N_BIT-1:0] w_rev;

    function automatic logic [N_BIT-1:0] bit_rev(input logic [N_BIT-1:0] n);
        logic [N_BIT-1:0] r;
        r = '0;
        for (int i = 0; i < N_BIT; i++) begin
            r[i] = n[N_BIT-1-i];
        end
        return r;
    endfunction

    always_comb begin
        oREADY = 1'b0;
        case (state_q)
            S_IDLE:  oREADY = iFHT_RDY;
            S_LOAD:  oREADY = 1'b1;
            default: oREADY = 1'b0;
        endcase
    end

    // SOF always restarts at index 0; non-SOF samples in IDLE are dropped.
    assign w_accept = iVALID & oREADY;
    assign w_write  = w_accept & (iSOF | (state_q == S_LOAD));
    assign w_index  = iSOF ? '0 : cnt_q[N_BIT-1:0];
    assign w_rev    = bit_rev(w_index);

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            start_q     <= 1'b0;
            sof_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            we_q      <= '0;
            start_q   <= 1'b0;
            sof_err_q <= 1'b0;

            if (w_write) begin
                we_q   <= 4'b0001 << w_rev[1:0];
                addr_q <= w_rev[N_BIT-1:2];
                data_q <= iDATA;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (w_accept && iSOF) begin
                        cnt_q   <= c_ONE;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (iSOF) begin
                            cnt_q     <= c_ONE;
                            sof_err_q <= 1'b1;
                        end else if (cnt_q == c_LAST) begin
                            cnt_q       <= '0;
                            start_q     <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            state_q     <= S_KICK;
                        end else begin
                            cnt_q <= cnt_q + c_ONE;
                        end
                    end
                end
                S_KICK:      state_q <= S_WAIT_BUSY;
                S_WAIT_BUSY: if (!iFHT_RDY) state_q <= S_WAIT_DONE;
                S_WAIT_DONE: if (iFHT_RDY)  state_q <= S_IDLE;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

    assign oWE_0      = we_q[0];
    assign oWE_1      = we_q[1];
    assign oWE_2      = we_q[2];
    assign oWE_3      = we_q[3];
    assign oADDR      = addr_q;
    assign oDATA      = data_q;
    assign oSTART     = start_q;
    assign oSOF_ERR   = sof_err_q;
    assign oBUSY      = (state_q != S_IDLE);
    assign oFRAME_CNT = frame_cnt_q;

endmodule
`default_nettype wire
